// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU instructions until both
// operands are resolved, snoops the ALU and LSB CDBs for wakeup, and issues
// the lowest-index ready entry each cycle on registered alu_* outputs.
// Handshake: dispatch is accepted on a cycle with disp_en_in=1 and
// rs_full_out=0 (dispatch must stall while full); alu_en_out=1 marks a valid
// issue for exactly one cycle and the ALU always consumes it.
module alu_reservation_station #(
  parameter int RS_DEPTH  = 16,
  parameter int ROB_TAG_W = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int TYPE_W    = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 disp_en_in,
  input  logic [TYPE_W-1:0]    disp_type_in,
  input  logic [DATA_W-1:0]    disp_vj_in,
  input  logic [DATA_W-1:0]    disp_vk_in,
  input  logic                 disp_qj_rdy_in,
  input  logic                 disp_qk_rdy_in,
  input  logic [ROB_TAG_W-1:0] disp_qj_in,
  input  logic [ROB_TAG_W-1:0] disp_qk_in,
  input  logic [DATA_W-1:0]    disp_A_in,
  input  logic [ROB_TAG_W-1:0] disp_dest_in,
  input  logic [ADDR_W-1:0]    disp_pc_in,
  output logic                 rs_full_out,
  input  logic                 cdb_alu_en_in,
  input  logic                 cdb_lsb_en_in,
  input  logic [ROB_TAG_W-1:0] cdb_alu_dest_in,
  input  logic [ROB_TAG_W-1:0] cdb_lsb_dest_in,
  input  logic [DATA_W-1:0]    cdb_alu_value_in,
  input  logic [DATA_W-1:0]    cdb_lsb_value_in,
  input  logic                 rob_flush_in,
  output logic                 alu_en_out,
  output logic [DATA_W-1:0]    alu_vj_out,
  output logic [DATA_W-1:0]    alu_vk_out,
  output logic [DATA_W-1:0]    alu_A_out,
  output logic [ROB_TAG_W-1:0] alu_dest_out,
  output logic [ADDR_W-1:0]    alu_pc_out,
  output logic [TYPE_W-1:0]    alu_type_out
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_DEPTH-1:0]  busy, qj_rdy, qk_rdy;
  logic [TYPE_W-1:0]    e_type [RS_DEPTH];
  logic [DATA_W-1:0]    e_vj   [RS_DEPTH];
  logic [DATA_W-1:0]    e_vk   [RS_DEPTH];
  logic [ROB_TAG_W-1:0] e_qj   [RS_DEPTH];
  logic [ROB_TAG_W-1:0] e_qk   [RS_DEPTH];
  logic [DATA_W-1:0]    e_a    [RS_DEPTH];
  logic [ROB_TAG_W-1:0] e_dest [RS_DEPTH];
  logic [ADDR_W-1:0]    e_pc   [RS_DEPTH];
  logic [CNT_W-1:0]     count;

  logic             free_found, issue_found, accept;
  logic [IDX_W-1:0] free_idx, issue_idx;
  logic [DATA_W-1:0] byp_vj, byp_vk;
  logic             byp_qj_rdy, byp_qk_rdy;

  assign rs_full_out = (count == CNT_W'(RS_DEPTH));
  assign accept      = disp_en_in && !rs_full_out && free_found;

  // Priority encoders: lowest free slot for dispatch, lowest ready slot for issue.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!free_found && !busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (!issue_found && busy[i] && qj_rdy[i] && qk_rdy[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
    end
  end

  // Same-cycle CDB bypass for the incoming instruction; ALU CDB wins ties.
  always_comb begin
    byp_vj     = disp_vj_in;
    byp_qj_rdy = disp_qj_rdy_in;
    byp_vk     = disp_vk_in;
    byp_qk_rdy = disp_qk_rdy_in;
    if (!disp_qj_rdy_in) begin
      if (cdb_alu_en_in && cdb_alu_dest_in == disp_qj_in) begin
        byp_vj = cdb_alu_value_in; byp_qj_rdy = 1'b1;
      end else if (cdb_lsb_en_in && cdb_lsb_dest_in == disp_qj_in) begin
        byp_vj = cdb_lsb_value_in; byp_qj_rdy = 1'b1;
      end
    end
    if (!disp_qk_rdy_in) begin
      if (cdb_alu_en_in && cdb_alu_dest_in == disp_qk_in) begin
        byp_vk = cdb_alu_value_in; byp_qk_rdy = 1'b1;
      end else if (cdb_lsb_en_in && cdb_lsb_dest_in == disp_qk_in) begin
        byp_vk = cdb_lsb_value_in; byp_qk_rdy = 1'b1;
      end
    end
  end

  // Entry storage: wakeup, dispatch write and issue-clear; flush wipes busy.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy   <= '0;
      qj_rdy <= '0;
      qk_rdy <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        e_type[i] <= '0; e_vj[i] <= '0; e_vk[i] <= '0; e_qj[i] <= '0;
        e_qk[i]   <= '0; e_a[i]  <= '0; e_dest[i] <= '0; e_pc[i] <= '0;
      end
    end else if (rdy_in) begin
      if (rob_flush_in) begin
        busy <= '0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (busy[i] && !qj_rdy[i]) begin
            if (cdb_alu_en_in && cdb_alu_dest_in == e_qj[i]) begin
              e_vj[i] <= cdb_alu_value_in; qj_rdy[i] <= 1'b1;
            end else if (cdb_lsb_en_in && cdb_lsb_dest_in == e_qj[i]) begin
              e_vj[i] <= cdb_lsb_value_in; qj_rdy[i] <= 1'b1;
            end
          end
          if (busy[i] && !qk_rdy[i]) begin
            if (cdb_alu_en_in && cdb_alu_dest_in == e_qk[i]) begin
              e_vk[i] <= cdb_alu_value_in; qk_rdy[i] <= 1'b1;
            end else if (cdb_lsb_en_in && cdb_lsb_dest_in == e_qk[i]) begin
              e_vk[i] <= cdb_lsb_value_in; qk_rdy[i] <= 1'b1;
            end
          end
        end
        if (issue_found) busy[issue_idx] <= 1'b0;
        if (accept) begin
          busy[free_idx]   <= 1'b1;
          qj_rdy[free_idx] <= byp_qj_rdy;
          qk_rdy[free_idx] <= byp_qk_rdy;
          e_vj[free_idx]   <= byp_vj;
          e_vk[free_idx]   <= byp_vk;
          e_qj[free_idx]   <= disp_qj_in;
          e_qk[free_idx]   <= disp_qk_in;
          e_type[free_idx] <= disp_type_in;
          e_a[free_idx]    <= disp_A_in;
          e_dest[free_idx] <= disp_dest_in;
          e_pc[free_idx]   <= disp_pc_in;
        end
      end
    end
  end

  // Occupancy counter and registered issue outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count        <= '0;
      alu_en_out   <= 1'b0;
      alu_vj_out   <= '0;
      alu_vk_out   <= '0;
      alu_A_out    <= '0;
      alu_dest_out <= '0;
      alu_pc_out   <= '0;
      alu_type_out <= '0;
    end else if (!rdy_in) begin
      alu_en_out <= 1'b0;
    end else if (rob_flush_in) begin
      count      <= '0;
      alu_en_out <= 1'b0;
    end else begin
      case ({accept, issue_found})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      alu_en_out <= issue_found;
      if (issue_found) begin
        alu_vj_out   <= e_vj[issue_idx];
        alu_vk_out   <= e_vk[issue_idx];
        alu_A_out    <= e_a[issue_idx];
        alu_dest_out <= e_dest[issue_idx];
        alu_pc_out   <= e_pc[issue_idx];
        alu_type_out <= e_type[issue_idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: reset, dispatch latency, CDB
// wakeup and bypass, full/drop, flush and global-stall behaviour.
module tb_alu_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        disp_en_in = 1'b0;
  logic [5:0]  disp_type_in = '0;
  logic [31:0] disp_vj_in = '0, disp_vk_in = '0, disp_A_in = '0, disp_pc_in = '0;
  logic        disp_qj_rdy_in = 1'b0, disp_qk_rdy_in = 1'b0;
  logic [3:0]  disp_qj_in = '0, disp_qk_in = '0, disp_dest_in = '0;
  logic        rs_full_out;
  logic        cdb_alu_en_in = 1'b0, cdb_lsb_en_in = 1'b0;
  logic [3:0]  cdb_alu_dest_in = '0, cdb_lsb_dest_in = '0;
  logic [31:0] cdb_alu_value_in = '0, cdb_lsb_value_in = '0;
  logic        rob_flush_in = 1'b0;
  logic        alu_en_out;
  logic [31:0] alu_vj_out, alu_vk_out, alu_A_out, alu_pc_out;
  logic [3:0]  alu_dest_out;
  logic [5:0]  alu_type_out;

  int n_checks = 0;
  int n_errors = 0;

  alu_reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_en_in(disp_en_in), .disp_type_in(disp_type_in),
    .disp_vj_in(disp_vj_in), .disp_vk_in(disp_vk_in),
    .disp_qj_rdy_in(disp_qj_rdy_in), .disp_qk_rdy_in(disp_qk_rdy_in),
    .disp_qj_in(disp_qj_in), .disp_qk_in(disp_qk_in),
    .disp_A_in(disp_A_in), .disp_dest_in(disp_dest_in), .disp_pc_in(disp_pc_in),
    .rs_full_out(rs_full_out),
    .cdb_alu_en_in(cdb_alu_en_in), .cdb_lsb_en_in(cdb_lsb_en_in),
    .cdb_alu_dest_in(cdb_alu_dest_in), .cdb_lsb_dest_in(cdb_lsb_dest_in),
    .cdb_alu_value_in(cdb_alu_value_in), .cdb_lsb_value_in(cdb_lsb_value_in),
    .rob_flush_in(rob_flush_in),
    .alu_en_out(alu_en_out), .alu_vj_out(alu_vj_out), .alu_vk_out(alu_vk_out),
    .alu_A_out(alu_A_out), .alu_dest_out(alu_dest_out), .alu_pc_out(alu_pc_out),
    .alu_type_out(alu_type_out)
  );

  // Clock: 10 time-unit period.
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs and checks happen 1 unit later.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_disp(input logic [5:0] ty, input logic [31:0] vj, input logic [31:0] vk,
                          input logic jr, input logic kr, input logic [3:0] qj,
                          input logic [3:0] qk, input logic [31:0] a,
                          input logic [3:0] dest, input logic [31:0] pc);
    disp_en_in = 1'b1; disp_type_in = ty; disp_vj_in = vj; disp_vk_in = vk;
    disp_qj_rdy_in = jr; disp_qk_rdy_in = kr; disp_qj_in = qj; disp_qk_in = qk;
    disp_A_in = a; disp_dest_in = dest; disp_pc_in = pc;
  endtask

  task automatic clr_disp();
    disp_en_in = 1'b0;
  endtask

  task automatic cdb_alu(input logic en, input logic [3:0] tag, input logic [31:0] val);
    cdb_alu_en_in = en; cdb_alu_dest_in = tag; cdb_alu_value_in = val;
  endtask

  task automatic cdb_lsb(input logic en, input logic [3:0] tag, input logic [31:0] val);
    cdb_lsb_en_in = en; cdb_lsb_dest_in = tag; cdb_lsb_value_in = val;
  endtask

  initial begin
    // Power-on reset.
    tick(); tick();
    check("rst_en", 32'(alu_en_out), 32'd0);
    check("rst_full", 32'(rs_full_out), 32'd0);
    check("rst_vj", alu_vj_out, 32'd0);
    check("rst_dest", 32'(alu_dest_out), 32'd0);
    rst_in = 1'b1;
    tick();

    // 1: five waiting entries, then async reset mid-cycle.
    for (int i = 0; i < 5; i++) begin
      set_disp(6'd1, 32'd0, 32'd0, 1'b0, 1'b1, 4'd1, 4'd0, 32'd0, 4'(i), 32'(i));
      tick();
    end
    clr_disp();
    #2 rst_in = 1'b0;
    #1;
    check("t1_async_en", 32'(alu_en_out), 32'd0);
    check("t1_async_full", 32'(rs_full_out), 32'd0);
    tick();
    rst_in = 1'b1;
    tick();
    set_disp(6'd1, 32'd3, 32'd4, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 4'd6, 32'h40);
    tick();
    clr_disp();
    check("t1_lat_edge1", 32'(alu_en_out), 32'd0);
    tick();
    check("t1_en", 32'(alu_en_out), 32'd1);
    check("t1_vj", alu_vj_out, 32'd3);
    check("t1_vk", alu_vk_out, 32'd4);
    check("t1_dest", 32'(alu_dest_out), 32'd6);
    check("t1_pc", alu_pc_out, 32'h40);
    check("t1_type", 32'(alu_type_out), 32'd1);
    tick();
    check("t1_en_drop", 32'(alu_en_out), 32'd0);
    // Entries lost in reset must not wake up on tag 1.
    cdb_alu(1'b1, 4'd1, 32'h11);
    tick();
    cdb_alu(1'b0, 4'd0, 32'd0);
    tick();
    check("t1_no_ghost", 32'(alu_en_out), 32'd0);

    // 2: ADDI waiting on tag 5, woken by the ALU CDB.
    set_disp(6'd2, 32'd0, 32'd0, 1'b0, 1'b1, 4'd5, 4'd0, 32'd10, 4'd3, 32'h100);
    tick();
    clr_disp();
    check("t2_wait", 32'(alu_en_out), 32'd0);
    cdb_alu(1'b1, 4'd5, 32'h20);
    tick();
    cdb_alu(1'b0, 4'd0, 32'd0);
    check("t2_not_yet", 32'(alu_en_out), 32'd0);
    tick();
    check("t2_en", 32'(alu_en_out), 32'd1);
    check("t2_vj", alu_vj_out, 32'h20);
    check("t2_A", alu_A_out, 32'd10);
    check("t2_dest", 32'(alu_dest_out), 32'd3);
    tick();
    check("t2_en_drop", 32'(alu_en_out), 32'd0);
    check("t2_vj_hold", alu_vj_out, 32'h20);

    // 3: same-cycle LSB bypass on qk = tag 2.
    set_disp(6'd3, 32'd1, 32'd0, 1'b1, 1'b0, 4'd0, 4'd2, 32'd0, 4'd4, 32'h104);
    cdb_lsb(1'b1, 4'd2, 32'h7);
    tick();
    clr_disp();
    cdb_lsb(1'b0, 4'd0, 32'd0);
    tick();
    check("t3_en", 32'(alu_en_out), 32'd1);
    check("t3_vk", alu_vk_out, 32'h7);
    check("t3_dest", 32'(alu_dest_out), 32'd4);

    // 3b: both CDBs hit tag 0 at dispatch; ALU CDB wins.
    set_disp(6'd3, 32'd0, 32'd5, 1'b0, 1'b1, 4'd0, 4'd0, 32'd0, 4'd8, 32'h108);
    cdb_alu(1'b1, 4'd0, 32'hA);
    cdb_lsb(1'b1, 4'd0, 32'hB);
    tick();
    clr_disp();
    cdb_alu(1'b0, 4'd0, 32'd0);
    cdb_lsb(1'b0, 4'd0, 32'd0);
    tick();
    check("t3b_en", 32'(alu_en_out), 32'd1);
    check("t3b_vj_prio", alu_vj_out, 32'hA);
    tick();

    // 4: fill all 16 entries waiting on tag 9, overflow dispatch dropped.
    for (int i = 0; i < 16; i++) begin
      set_disp(6'd4, 32'd0, 32'(i), 1'b0, 1'b1, 4'd9, 4'd0, 32'd0, 4'(i), 32'h200 + 32'(i));
      tick();
      if (i == 14) check("t4_full_at15", 32'(rs_full_out), 32'd0);
    end
    check("t4_full", 32'(rs_full_out), 32'd1);
    set_disp(6'd4, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 4'd15, 32'hDEAD);
    tick();
    clr_disp();
    check("t4_full_hold", 32'(rs_full_out), 32'd1);
    check("t4_no_issue", 32'(alu_en_out), 32'd0);
    cdb_alu(1'b1, 4'd9, 32'h99);
    tick();
    cdb_alu(1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t4_seq_en", 32'(alu_en_out), 32'd1);
      check("t4_seq_pc", alu_pc_out, 32'h200 + 32'(i));
      check("t4_seq_vj", alu_vj_out, 32'h99);
    end
    check("t4_full_clear", 32'(rs_full_out), 32'd0);
    tick();
    check("t4_drained", 32'(alu_en_out), 32'd0);

    // 5: flush with 3 ready entries plus same-cycle dispatch.
    for (int i = 0; i < 3; i++) begin
      set_disp(6'd5, 32'd0, 32'd0, 1'b0, 1'b1, 4'd7, 4'd0, 32'd0, 4'(i), 32'h300 + 32'(i));
      tick();
    end
    clr_disp();
    cdb_alu(1'b1, 4'd7, 32'h77);
    tick();
    cdb_alu(1'b0, 4'd0, 32'd0);
    rob_flush_in = 1'b1;
    set_disp(6'd5, 32'd1, 32'd2, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 4'd9, 32'h3FF);
    tick();
    rob_flush_in = 1'b0;
    clr_disp();
    check("t5_flush_en", 32'(alu_en_out), 32'd0);
    check("t5_flush_full", 32'(rs_full_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_issue", 32'(alu_en_out), 32'd0);
    end

    // 6: global stall with 2 ready entries and a CDB pulse.
    set_disp(6'd6, 32'd0, 32'd0, 1'b0, 1'b1, 4'd8, 4'd0, 32'd0, 4'd1, 32'h10);
    tick();
    set_disp(6'd6, 32'd0, 32'd0, 1'b0, 1'b1, 4'd8, 4'd0, 32'd0, 4'd2, 32'h14);
    tick();
    set_disp(6'd6, 32'd0, 32'd0, 1'b0, 1'b1, 4'd11, 4'd0, 32'd0, 4'd3, 32'h18);
    tick();
    clr_disp();
    cdb_alu(1'b1, 4'd8, 32'h88);
    tick();
    rdy_in = 1'b0;
    cdb_alu(1'b1, 4'd11, 32'hBB);
    set_disp(6'd6, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 4'd4, 32'h77);
    tick();
    cdb_alu(1'b0, 4'd0, 32'd0);
    clr_disp();
    check("t6_stall1", 32'(alu_en_out), 32'd0);
    tick();
    check("t6_stall2", 32'(alu_en_out), 32'd0);
    tick();
    check("t6_stall3", 32'(alu_en_out), 32'd0);
    rdy_in = 1'b1;
    tick();
    check("t6_res_en0", 32'(alu_en_out), 32'd1);
    check("t6_res_pc0", alu_pc_out, 32'h10);
    check("t6_res_vj0", alu_vj_out, 32'h88);
    tick();
    check("t6_res_en1", 32'(alu_en_out), 32'd1);
    check("t6_res_pc1", alu_pc_out, 32'h14);
    tick();
    check("t6_no_capture", 32'(alu_en_out), 32'd0);
    cdb_lsb(1'b1, 4'd11, 32'hCC);
    tick();
    cdb_lsb(1'b0, 4'd0, 32'd0);
    tick();
    check("t6_late_en", 32'(alu_en_out), 32'd1);
    check("t6_late_pc", alu_pc_out, 32'h18);
    check("t6_late_vj", alu_vj_out, 32'hCC);
    tick();
    check("t6_empty", 32'(alu_en_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
